aircon_bargraph_ctrl: RTL and testbench

Parametrised, clocked successor of the aircon front-panel display decoder. Takes a one-hot mode selector plus a turbo flag, computes a target fan/cool level, and ramps a thermometer-coded bar graph toward it one segment per tick. It filters short invalid-input glitches and latches a debounced error state. It sits between the panel switch/thermostat inputs and the LED bar-graph driver.

---
 rtl/aircon_pkg.sv | 26 ++
 rtl/aircon_target_dec.sv | 40 ++++
 rtl/aircon_bargraph_ctrl.sv | 177 +++++++++++++++++
 tb/tb_aircon_bargraph_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/aircon_pkg.sv
// Shared state encoding and decode helpers for the aircon bar-graph controller.
package aircon_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // True for all-zero or exactly one bit set.
    function automatic logic is_onehot0(input logic [MAX_W-1:0] v);
        return (v & (v - 32'd1)) == '0;
    endfunction

    function automatic logic [MAX_W-1:0] level_to_thermo(input logic [MAX_W-1:0] lvl);
        logic [MAX_W-1:0] t;
        t = '0;
        for (int j = 0; j < MAX_W; j++) begin
            t[j] = (32'(j) < lvl);
        end
        return t;
    endfunction

endpackage

// File: rtl/aircon_target_dec.sv
// Combinational decode of the registered panel sample into a validity flag and target level.
module aircon_target_dec
    import aircon_pkg::*;
#(
    parameter int MODES = 4,
    parameter int SEGS  = 8,
    parameter int LW    = $clog2(SEGS + 1)
) (
    input  logic [MODES-1:0] thermo_i,
    input  logic             turbo_i,
    input  logic [MODES-1:0] lv_thermo_i,
    input  logic             lv_turbo_i,
    output logic             valid_o,
    output logic [LW-1:0]    target_o
);

    logic [MODES-1:0] sel_thermo;
    logic             sel_turbo;
    logic [LW-1:0]    mode_lvl [MODES];

    assign valid_o    = is_onehot0(MAX_W'(thermo_i));
    assign sel_thermo = valid_o ? thermo_i : lv_thermo_i;
    assign sel_turbo  = valid_o ? turbo_i  : lv_turbo_i;

    // Each mode contributes its constant level only when selected; OFF leaves all zero.
    for (genvar gi = 0; gi < MODES; gi++) begin : g_mode
        localparam int BASE  = ((gi + 1) * SEGS) / MODES;
        localparam int BOOST = (BASE + SEGS / MODES > SEGS) ? SEGS : BASE + SEGS / MODES;
        assign mode_lvl[gi] = !sel_thermo[gi] ? '0 :
                              sel_turbo       ? LW'(BOOST) : LW'(BASE);
    end

    always_comb begin
        target_o = '0;
        for (int i = 0; i < MODES; i++) begin
            target_o = target_o | mode_lvl[i];
        end
    end

endmodule

// File: rtl/aircon_bargraph_ctrl.sv
// Ramping thermometer bar-graph controller with glitch filter and debounced error state.
// Define AIRCON_ERR_BLINK_EN to blink the whole bar while in ERROR.
module aircon_bargraph_ctrl
    import aircon_pkg::*;
#(
    parameter int MODES     = 4,
    parameter int SEGS      = 8,
    parameter int TICK_DIV  = 4,
    parameter int ERR_CYC   = 3,
    parameter int BLINK_CYC = 8
) (
    input  logic                       Clk_In,
    input  logic                       nRst_In,
    input  logic [MODES-1:0]           Thermo_In,
    input  logic                       Turbo_In,
    output logic [SEGS-1:0]            BGraph_Out,
    output logic [$clog2(SEGS+1)-1:0]  Level_Out,
    output logic                       Err_Out,
    output logic                       Busy_Out
);

    localparam int LW = $clog2(SEGS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(ERR_CYC + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ERR_MAX  = CW'(ERR_CYC);

    logic [MODES-1:0] thermo_q, lv_thermo_q, lv_thermo_d;
    logic             turbo_q, lv_turbo_q, lv_turbo_d;
    logic [CW-1:0]    inv_cnt_q, inv_cnt_d, val_cnt_q, val_cnt_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [LW-1:0]    level_q, level_d, step_lvl, target;
    state_t           state_q, state_d;
    logic             err_q, err_d, busy_q, busy_d, valid;
    logic [SEGS-1:0]  bgraph_q, bgraph_d, err_bar;

    aircon_target_dec #(
        .MODES (MODES),
        .SEGS  (SEGS),
        .LW    (LW)
    ) u_dec (
        .thermo_i    (thermo_q),
        .turbo_i     (turbo_q),
        .lv_thermo_i (lv_thermo_q),
        .lv_turbo_i  (lv_turbo_q),
        .valid_o     (valid),
        .target_o    (target)
    );

    assign lv_thermo_d = valid ? thermo_q : lv_thermo_q;
    assign lv_turbo_d  = valid ? turbo_q  : lv_turbo_q;
    assign inv_cnt_d   = valid ? '0 : (inv_cnt_q == ERR_MAX) ? ERR_MAX : inv_cnt_q + CW'(1);
    assign val_cnt_d   = !valid ? '0 : (val_cnt_q == ERR_MAX) ? ERR_MAX : val_cnt_q + CW'(1);
    assign step_lvl    = (target > level_q) ? level_q + LW'(1) : level_q - LW'(1);

    // Error entry is tested first so it pre-empts any step on the same edge.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tick_d  = tick_q;
        unique case (state_q)
            ST_HOLD: begin
                if (inv_cnt_d == ERR_MAX) begin
                    state_d = ST_ERROR;
                    level_d = '0;
                end else if (target != level_q) begin
                    state_d = ST_RAMP;
                    tick_d  = '0;
                end
            end
            ST_RAMP: begin
                if (inv_cnt_d == ERR_MAX) begin
                    state_d = ST_ERROR;
                    level_d = '0;
                end else if (target == level_q) begin
                    state_d = ST_HOLD;
                end else begin
                    tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + TW'(1);
                    if (tick_q == TICK_MAX) begin
                        level_d = step_lvl;
                        if (step_lvl == target) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_ERROR: begin
                level_d = '0;
                if (val_cnt_d == ERR_MAX) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_HOLD;
                level_d = '0;
            end
        endcase
    end

`ifdef AIRCON_ERR_BLINK_EN
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYC - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    // Phase restarts lit on every entry edge.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b0;
        if (state_d == ST_ERROR) begin
            if (state_q != ST_ERROR) begin
                blink_on_d = 1'b1;
            end else if (blink_cnt_q == BLINK_MAX) begin
                blink_on_d = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_on_d  = blink_on_q;
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        if (!nRst_In) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign err_bar = blink_on_d ? '1 : '0;
`else
    assign err_bar = '0;
`endif

    assign busy_d   = (state_d == ST_RAMP);
    assign err_d    = (state_d == ST_ERROR);
    assign bgraph_d = err_d ? err_bar : SEGS'(level_to_thermo(MAX_W'(level_d)));

    always_ff @(posedge Clk_In) begin
        if (!nRst_In) begin
            thermo_q    <= '0;
            turbo_q     <= 1'b0;
            lv_thermo_q <= '0;
            lv_turbo_q  <= 1'b0;
            inv_cnt_q   <= '0;
            val_cnt_q   <= '0;
            tick_q      <= '0;
            level_q     <= '0;
            state_q     <= ST_HOLD;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            bgraph_q    <= '0;
        end else begin
            thermo_q    <= Thermo_In;
            turbo_q     <= Turbo_In;
            lv_thermo_q <= lv_thermo_d;
            lv_turbo_q  <= lv_turbo_d;
            inv_cnt_q   <= inv_cnt_d;
            val_cnt_q   <= val_cnt_d;
            tick_q      <= tick_d;
            level_q     <= level_d;
            state_q     <= state_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            bgraph_q    <= bgraph_d;
        end
    end

    assign BGraph_Out = bgraph_q;
    assign Level_Out  = level_q;
    assign Err_Out    = err_q;
    assign Busy_Out   = busy_q;

endmodule

// File: tb/tb_aircon_bargraph_ctrl.sv
// Bench for aircon_bargraph_ctrl: directed vector table, blink/error sequence, random run vs model.
module tb_aircon_bargraph_ctrl;

    localparam int MODES     = 4;
    localparam int SEGS      = 8;
    localparam int TICK_DIV  = 4;
    localparam int ERR_CYC   = 3;
    localparam int BLINK_CYC = 8;
    localparam int LW        = $clog2(SEGS + 1);
`ifdef AIRCON_ERR_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam int ERR_BAR = BLINK ? 8'hFF : 8'h00;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [MODES-1:0] thermo = '0;
    logic             turbo = 1'b0;
    logic [SEGS-1:0]  bgraph;
    logic [LW-1:0]    level;
    logic             err, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aircon_bargraph_ctrl #(
        .MODES     (MODES),
        .SEGS      (SEGS),
        .TICK_DIV  (TICK_DIV),
        .ERR_CYC   (ERR_CYC),
        .BLINK_CYC (BLINK_CYC)
    ) dut (
        .Clk_In     (clk),
        .nRst_In    (rst_n),
        .Thermo_In  (thermo),
        .Turbo_In   (turbo),
        .BGraph_Out (bgraph),
        .Level_Out  (level),
        .Err_Out    (err),
        .Busy_Out   (busy)
    );

    // Reference model state: what the panel should show, tracked cycle by cycle.
    logic [MODES-1:0] m_samp = '0, m_lv = '0;
    logic             m_samp_turbo = 1'b0, m_lv_turbo = 1'b0;
    int               m_inv = 0, m_val = 0, m_lvl = 0, m_phase = 0, m_age = 0;
    bit               m_err = 1'b0, m_ramp = 1'b0;

    function automatic int tgt_of(input logic [MODES-1:0] th, input logic tb);
        int t = 0;
        for (int i = 0; i < MODES; i++) if (th[i]) t = ((i + 1) * SEGS) / MODES;
        if (th != 0 && tb) t = (t + SEGS / MODES > SEGS) ? SEGS : t + SEGS / MODES;
        return t;
    endfunction

    function automatic int model_bar();
        if (m_err) return (BLINK && ((m_age / BLINK_CYC) % 2 == 0)) ? 8'hFF : 0;
        return (1 << m_lvl) - 1;
    endfunction

    task automatic model_edge();
        bit v;
        int tgt, n_inv, n_val;
        if (!rst_n) begin
            m_samp = '0; m_lv = '0; m_samp_turbo = 0; m_lv_turbo = 0;
            m_inv = 0; m_val = 0; m_lvl = 0; m_phase = 0; m_age = 0;
            m_err = 0; m_ramp = 0;
            return;
        end
        v     = ($countones(m_samp) <= 1);
        tgt   = v ? tgt_of(m_samp, m_samp_turbo) : tgt_of(m_lv, m_lv_turbo);
        n_inv = v ? 0 : ((m_inv + 1 > ERR_CYC) ? ERR_CYC : m_inv + 1);
        n_val = v ? ((m_val + 1 > ERR_CYC) ? ERR_CYC : m_val + 1) : 0;
        if (m_err) begin
            m_age++;
            if (n_val == ERR_CYC) m_err = 0;
        end else if (n_inv == ERR_CYC) begin
            m_err = 1; m_ramp = 0; m_lvl = 0; m_age = 0;
        end else if (!m_ramp) begin
            if (tgt != m_lvl) begin m_ramp = 1; m_phase = 0; end
        end else if (tgt == m_lvl) begin
            m_ramp = 0;
        end else begin
            if (m_phase == TICK_DIV - 1) begin
                m_lvl += (tgt > m_lvl) ? 1 : -1;
                if (m_lvl == tgt) m_ramp = 0;
            end
            m_phase = (m_phase + 1) % TICK_DIV;
        end
        if (v) begin m_lv = m_samp; m_lv_turbo = m_samp_turbo; end
        m_inv = n_inv; m_val = n_val;
        m_samp = thermo; m_samp_turbo = turbo;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("model_level", int'(level), m_lvl);
            check("model_err", int'(err), int'(m_err));
            check("model_busy", int'(busy), int'(m_ramp));
            check("model_bgraph", int'(bgraph), model_bar());
        end
    endtask

    typedef struct packed {
        logic       rst_n;
        logic [3:0] thermo;
        logic       turbo;
        int         ncyc;
        int         lvl;
        logic       err;
        logic       busy;
        logic [7:0] bar;
    } vec_t;

    vec_t vecs[$];

    initial begin
        //                rst  thermo turbo ncyc lvl err busy bar
        vecs.push_back('{1'b0, 4'h0, 1'b0,  2, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'h0, 1'b0,  3, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'h1, 1'b0,  2, 0, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 4'h1, 1'b0,  4, 1, 1'b0, 1'b1, 8'h01});
        vecs.push_back('{1'b1, 4'h1, 1'b0,  4, 2, 1'b0, 1'b0, 8'h03});
        vecs.push_back('{1'b1, 4'h8, 1'b1, 25, 7, 1'b0, 1'b1, 8'h7F});
        vecs.push_back('{1'b1, 4'h8, 1'b1,  1, 8, 1'b0, 1'b0, 8'hFF});
        vecs.push_back('{1'b1, 4'h0, 1'b0, 18, 4, 1'b0, 1'b1, 8'h0F});
        vecs.push_back('{1'b1, 4'h0, 1'b0, 16, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'h2, 1'b0, 18, 4, 1'b0, 1'b0, 8'h0F});
        vecs.push_back('{1'b1, 4'hF, 1'b0,  2, 4, 1'b0, 1'b0, 8'h0F});
        vecs.push_back('{1'b1, 4'h2, 1'b0,  4, 4, 1'b0, 1'b0, 8'h0F});
        vecs.push_back('{1'b1, 4'hF, 1'b0,  3, 4, 1'b0, 1'b0, 8'h0F});
        vecs.push_back('{1'b1, 4'hF, 1'b0,  1, 0, 1'b1, 1'b0, 8'(ERR_BAR)});
        vecs.push_back('{1'b1, 4'h2, 1'b1,  3, 0, 1'b1, 1'b0, 8'(ERR_BAR)});
        vecs.push_back('{1'b1, 4'h2, 1'b1,  1, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'h2, 1'b1,  1, 0, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 4'h2, 1'b1, 24, 6, 1'b0, 1'b0, 8'h3F});
        vecs.push_back('{1'b1, 4'h0, 1'b0, 26, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'h2, 1'b1, 14, 3, 1'b0, 1'b1, 8'h07});
        vecs.push_back('{1'b1, 4'h1, 1'b0,  3, 3, 1'b0, 1'b1, 8'h07});
        vecs.push_back('{1'b1, 4'h1, 1'b0,  1, 2, 1'b0, 1'b0, 8'h03});
        vecs.push_back('{1'b1, 4'h8, 1'b0, 14, 5, 1'b0, 1'b1, 8'h1F});
        vecs.push_back('{1'b0, 4'h8, 1'b0,  1, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'hF, 1'b0,  2, 0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 4'h0, 1'b0,  3, 0, 1'b0, 1'b0, 8'h00});

        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            thermo = vecs[i].thermo;
            turbo  = vecs[i].turbo;
            step(vecs[i].ncyc);
            check($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].err));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            check($sformatf("vec%0d_bgraph", i), int'(bgraph), int'(vecs[i].bar));
            $display("vec %0d thermo=%b turbo=%0d -> level=%0d err=%0d busy=%0d bgraph=%b",
                     i, vecs[i].thermo, vecs[i].turbo, level, err, busy, bgraph);
        end

        // Long error: bar lit on entry, dark after BLINK_CYC, lit again (blink build only).
        thermo = 4'h5; turbo = 1'b0;
        step(4);
        check("err_entry_flag", int'(err), 1);
        check("err_entry_bar", int'(bgraph), ERR_BAR);
        step(7);
        check("err_first_half_bar", int'(bgraph), ERR_BAR);
        step(1);
        check("err_second_half_bar", int'(bgraph), 0);
        check("err_level_zero", int'(level), 0);
        step(8);
        check("err_third_half_bar", int'(bgraph), ERR_BAR);
        $display("error blink sequence done bgraph=%b err=%0d", bgraph, err);
        thermo = 4'h0;
        step(4);
        check("err_exit_flag", int'(err), 0);

        // Random stimulus; the model comparisons inside step() do the checking.
        for (int t = 0; t < 120; t++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r < 2)      thermo = '0;
            else if (r < 7) thermo = 4'(1 << $urandom_range(0, MODES - 1));
            else            thermo = 4'($urandom_range(0, 15));
            turbo = 1'($urandom_range(0, 1));
            len   = $urandom_range(1, 12);
            if ($urandom_range(0, 30) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(len);
            $display("rand %0d thermo=%b turbo=%0d len=%0d -> level=%0d err=%0d busy=%0d",
                     t, thermo, turbo, len, level, err, busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
